// File: rtl/kmeans_pkg.sv
// Shared constants, FSM encoding and slice helpers for the k-means new-mean stage.
package kmeans_pkg;

    localparam int DEF_CENTROID_NUM = 8;
    localparam int DEF_DIM          = 7;
    localparam int DEF_COORD_W      = 13;
    localparam int DEF_ACC_W        = 22;
    localparam int DEF_CNT_W        = 10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
        S_POST = 3'd3,
        S_OUT  = 3'd4,
        S_FIN  = 3'd5
    } nmc_state_t;

    // LSB of centroid c, coordinate d in a flattened {centroid, coordinate} bus
    function automatic int coord_lsb(input int c, input int d, input int dim, input int w);
        return (c * dim + d) * w;
    endfunction

    function automatic int cent_lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/seq_div_restoring.sv
// Restoring unsigned divider: one quotient bit per cycle, N cycles after load.
module seq_div_restoring #(
    parameter int N = 22,
    parameter int M = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_dividend,
    input  logic [M-1:0] i_divisor,
    output logic         o_busy,
    output logic [N-1:0] o_quot,
    output logic [M-1:0] o_rem
);
    localparam int CNT_BITS = $clog2(N + 1);

    logic [N-1:0]        r_quot;
    logic [M-1:0]        r_rem;
    logic [CNT_BITS-1:0] r_steps;
    logic [M:0]          w_shift;
    logic [M:0]          w_sub;
    logic                w_ge;

    assign w_shift = {r_rem, r_quot[N-1]};
    assign w_sub   = w_shift - {1'b0, i_divisor};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_steps <= '0;
        end else if (i_load) begin
            r_quot  <= i_dividend;
            r_rem   <= '0;
            r_steps <= CNT_BITS'(N);
        end else if (r_steps != '0) begin
            r_rem   <= w_ge ? w_sub[M-1:0] : w_shift[M-1:0];
            r_quot  <= {r_quot[N-2:0], w_ge};
            r_steps <= r_steps - 1'b1;
        end
    end

    // Drops during the final step, so the result is ready on the following cycle.
    assign o_busy = (r_steps > CNT_BITS'(1));
    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/new_means_calc_seq.sv
// Sequential k-means new-mean stage: accum/cnt per coordinate, one centroid streamed at a time.
module new_means_calc_seq
    import kmeans_pkg::*;
#(
    parameter int CENTROID_NUM = DEF_CENTROID_NUM,
    parameter int DIM          = DEF_DIM,
    parameter int COORD_W      = DEF_COORD_W,
    parameter int ACC_W        = DEF_ACC_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int ROUND_EN     = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_start,
    input  logic [CENTROID_NUM*DIM*ACC_W-1:0]     i_accum,
    input  logic [CENTROID_NUM*CNT_W-1:0]         i_cnt,
    input  logic [CENTROID_NUM*DIM*COORD_W-1:0]   i_old_means,
    output logic                                  o_busy,
    output logic                                  o_mean_valid,
    input  logic                                  i_mean_ready,
    output logic [$clog2(CENTROID_NUM)-1:0]       o_mean_idx,
    output logic [DIM*COORD_W-1:0]                o_mean_data,
    output logic                                  o_div_by_0,
    output logic                                  o_done
);
    localparam int IDX_W = $clog2(CENTROID_NUM);
    localparam int D_W   = (DIM > 1) ? $clog2(DIM) : 1;

    nmc_state_t               r_state;
    logic [IDX_W-1:0]         r_c;
    logic [D_W-1:0]           r_d;
    logic [DIM*COORD_W-1:0]   r_mean;
    logic                     r_valid;
    logic                     r_dbz;

    logic [CNT_W-1:0]         w_cnt;
    logic [ACC_W-1:0]         w_acc;
    logic [DIM*COORD_W-1:0]   w_old;
    logic                     w_div_load;
    logic                     w_div_busy;
    logic [ACC_W-1:0]         w_quot;
    logic [CNT_W-1:0]         w_rem;
    logic                     w_inc;
    logic [ACC_W:0]           w_q_ext;
    logic [COORD_W-1:0]       w_coord;
    logic                     w_last_d;
    logic                     w_last_c;

    // Operands are read straight from the producer's buses, which stay stable while busy.
    assign w_cnt      = i_cnt[cent_lsb(int'(r_c), CNT_W) +: CNT_W];
    assign w_acc      = i_accum[coord_lsb(int'(r_c), int'(r_d), DIM, ACC_W) +: ACC_W];
    assign w_old      = i_old_means[coord_lsb(int'(r_c), 0, DIM, COORD_W) +: DIM*COORD_W];
    assign w_div_load = (r_state == S_LOAD) && (w_cnt != '0);
    assign w_last_d   = (r_d == D_W'(DIM - 1));
    assign w_last_c   = (r_c == IDX_W'(CENTROID_NUM - 1));

    seq_div_restoring #(
        .N(ACC_W),
        .M(CNT_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_div_load),
        .i_dividend(w_acc),
        .i_divisor (w_cnt),
        .o_busy    (w_div_busy),
        .o_quot    (w_quot),
        .o_rem     (w_rem)
    );

    // Round half up: remainder at least half the divisor bumps the quotient.
    assign w_inc   = (ROUND_EN != 0) && ({w_rem, 1'b0} >= {1'b0, w_cnt});
    assign w_q_ext = {1'b0, w_quot} + {{ACC_W{1'b0}}, w_inc};
    assign w_coord = (|w_q_ext[ACC_W:COORD_W]) ? {COORD_W{1'b1}} : w_q_ext[COORD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_mean  <= '0;
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_c     <= '0;
                        r_d     <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_cnt == '0) begin
                        r_mean  <= w_old;
                        r_dbz   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (!w_div_busy) r_state <= S_POST;
                end
                S_POST: begin
                    r_mean[int'(r_d)*COORD_W +: COORD_W] <= w_coord;
                    if (w_last_d) begin
                        r_valid <= 1'b1;
                        r_dbz   <= 1'b0;
                        r_state <= S_OUT;
                    end else begin
                        r_d     <= r_d + 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_OUT: begin
                    if (i_mean_ready) begin
                        r_valid <= 1'b0;
                        if (w_last_c) begin
                            r_state <= S_FIN;
                        end else begin
                            r_c     <= r_c + 1'b1;
                            r_d     <= '0;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_FIN);
    assign o_mean_valid = r_valid;
    assign o_mean_idx   = r_c;
    assign o_mean_data  = r_mean;
    assign o_div_by_0   = r_dbz;

endmodule

// File: doc/new_means_calc_seq.md
Name: new_means_calc_seq

Overview:
- Parametrised, sequential successor of the k-means new-mean divider stage.
- After a classification pass, computes each centroid's new mean as accum/count, per coordinate, for all centroids.
- Streams one centroid at a time, with valid/ready, to the convergence check block.
- Handles empty clusters and rounding, and saturates to the coordinate width.

Parameters:
- CENTROID_NUM, 8, number of centroids (K)
- DIM, 7, coordinates per point
- COORD_W, 13, unsigned coordinate width
- ACC_W, 22, unsigned per-coordinate accumulator width
- CNT_W, 10, unsigned per-centroid point-count width
- ROUND_EN, 0, 0 = truncate quotient, 1 = round half up

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a pass (accepted only in IDLE)
- accum  in  CENTROID_NUM*DIM*ACC_W  sums; centroid c, coordinate d at slice (c*DIM+d)*ACC_W
- cnt  in  CENTROID_NUM*CNT_W  point counts per centroid
- old_means  in  CENTROID_NUM*DIM*COORD_W  current means, used for empty clusters
- busy  out  1  high from accepted start until done
- mean_valid  out  1  mean_data holds a complete centroid
- mean_ready  in  1  consumer accepts when mean_valid && mean_ready
- mean_idx  out  $clog2(CENTROID_NUM)  centroid index of mean_data
- mean_data  out  DIM*COORD_W  new mean, coordinate d at slice d*COORD_W
- div_by_0  out  1  qualifies mean_data: cnt was 0, old mean passed through
- done  out  1  one-cycle pulse after the last centroid is accepted

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy, mean_valid, div_by_0, done, mean_idx, mean_data all 0. Reset mid-pass aborts the pass; no partial output.
- Inputs accum/cnt/old_means must be held stable by the producer while busy; the block does not capture them.
- FSM states: IDLE, LOAD, DIV, POST, OUT, FIN.
  - IDLE: on start -> LOAD with c=0, d=0. start in any other state is ignored.
  - LOAD (1 cycle):
    - if cnt[c]==0: copy old_means[c] entirely into mean_data, set div_by_0=1, go to OUT.
    - else: load the divider with accum[c][d] and cnt[c], go to DIV.
  - DIV: restoring unsigned divide, one quotient bit per cycle, exactly ACC_W cycles -> POST.
  - POST (1 cycle):
    - q = quotient; if ROUND_EN and 2*rem >= cnt, q = q+1 (ACC_W+1-bit add).
    - If q > 2^COORD_W-1, q = 2^COORD_W-1 (saturate).
    - Write q into coordinate d of mean_data.
    - If d < DIM-1: d++, go to LOAD. Otherwise mean_valid=1, div_by_0=0, go to OUT.
  - OUT:
    - Hold mean_data, mean_idx and div_by_0 stable while mean_valid && !mean_ready.
    - On handshake: mean_valid=0. If c == CENTROID_NUM-1 go to FIN, else c++, d=0, go to LOAD.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Latency:
  - Non-empty centroid: DIM*(ACC_W+2) cycles from entering LOAD to mean_valid (7*24 = 168 at defaults).
  - Empty centroid: 1 cycle.
  - Full pass with ready tied high: sum of the per-centroid latencies + CENTROID_NUM handshake cycles + 1 (FIN).
- mean_idx = c, valid whenever mean_valid=1. Centroids are emitted strictly in order 0..CENTROID_NUM-1.
- cnt=1 gives an exact quotient = accum, saturated.
- done and start in the same cycle: start is ignored, because the FSM is not in IDLE.

Decomposition:
- Package kmeans_pkg:
  - default width constants (COORD_W, ACC_W, CNT_W, CENTROID_NUM, DIM)
  - state enum typedef nmc_state_t
  - slice-index helper functions
- Sub-module seq_div_restoring:
  - parameters N (dividend width) and M (divisor width)
  - ports: clk, rst, load, dividend, divisor, busy, quot, rem
  - ACC_W-cycle restoring divide; instantiated once and reused across all coordinates.
- Top: FSM, counters c/d, round/saturate logic, output register.

Test Plan:
- K=8, DIM=7, accum[0][*]=1000, cnt[0]=3, ROUND_EN=0, ready=1 -> mean_idx=0, all coordinates 333, div_by_0=0, mean_valid exactly 168 cycles after LOAD.
- ROUND_EN=1, accum=1001, cnt=2 -> 501; accum=1000, cnt=3 -> 333 (rem 1, not rounded).
- accum=2^21 (exceeds COORD_W), cnt=1 -> 8191 saturated; accum=0, cnt=5 -> 0.
- cnt[3]=0, old_means[3][*]=42 -> centroid 3 emitted with all coordinates 42 and div_by_0=1, 1 cycle after LOAD; neighbouring centroids unaffected.
- Hold mean_ready=0 for 20 cycles on centroid 2 -> mean_data and mean_idx stable, no advance; on release, centroid 3 computes next and done pulses once after centroid 7 is accepted.
- Assert rst during DIV of centroid 4 -> all outputs 0 immediately; a later start begins again at centroid 0. A second start pulse while busy -> ignored, output sequence unchanged.
